piso_deb_ctrl: RTL

Sequencer and byte sink for the 12-byte debug PISO snapshot chain. On a debug request it drives the PISO's CLR_PISO_DEB, EN_PISO_DEB and SHIFT_DEB strobes to clear, capture and shift one snapshot. It collects each shifted byte from the PISO's D_OUT into a small FIFO, then presents the bytes to the host-side debug port with a valid/ready handshake and a last-byte marker.

---
 rtl/piso_deb_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/piso_deb_ctrl.sv
// rtl/piso_deb_ctrl.sv - debug PISO snapshot sequencer with byte FIFO and valid/ready host port
module piso_deb_ctrl #(
    parameter int NBYTES     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLKEXT,
    input  logic       RST_GLO,
    input  logic       DBG_REQ,
    input  logic       DBG_ABORT,
    output logic       EN_PISO_DEB,
    output logic       CLR_PISO_DEB,
    output logic       SHIFT_DEB,
    input  logic [7:0] DEB_DIN,
    output logic [7:0] BYTE_OUT,
    output logic       BYTE_VALID,
    input  logic       BYTE_READY,
    output logic       BYTE_LAST,
    output logic [3:0] BYTE_IDX,
    output logic       DBG_BUSY,
    output logic       DBG_DONE
);

    localparam int PW = $clog2(FIFO_DEPTH);

    // Sized constants so every compare is width-exact
    localparam logic [3:0]  LP_NB     = 4'(NBYTES);
    localparam logic [3:0]  LP_NB_M1  = 4'(NBYTES - 1);
    localparam logic [PW:0] LP_FULL   = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW+1:0] LP_CRED = (PW + 2)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_DONE      = 3'd5,
        ST_ABORT_CLR = 3'd6
    } state_t;

    state_t        r_state;
    logic [3:0]    r_issued;
    logic [3:0]    r_popped;
    logic          r_shift_d;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_abort;
    logic          w_shift;
    logic [PW+1:0] w_occ;

    // A byte in flight (shift_d) already holds a FIFO slot, so it counts as credit used;
    // pops in this cycle are deliberately not credited so the strobe never depends on BYTE_READY.
    assign w_empty = (r_count == '0);
    assign w_push  = r_shift_d;
    assign w_pop   = !w_empty && BYTE_READY;
    assign w_abort = DBG_ABORT && (r_state != ST_IDLE);
    assign w_occ   = {1'b0, r_count} + {{(PW + 1){1'b0}}, r_shift_d};
    assign w_shift = (r_state == ST_SHIFT) && (r_issued < LP_NB) && (w_occ < LP_CRED);

    // Sequencer: strobe phases, issued-shift counter and host-side pop counter
    always_ff @(posedge CLKEXT) begin
        if (RST_GLO) begin
            r_state  <= ST_IDLE;
            r_issued <= '0;
            r_popped <= '0;
        end else if (w_abort) begin
            r_state <= ST_ABORT_CLR;
        end else begin
            if (w_pop) begin
                r_popped <= r_popped + 4'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (DBG_REQ) begin
                        r_state  <= ST_CLEAR;
                        r_issued <= '0;
                        r_popped <= '0;
                    end
                end
                ST_CLEAR:   r_state <= ST_CAPTURE;
                ST_CAPTURE: r_state <= ST_SHIFT;
                ST_SHIFT: begin
                    if (w_shift) begin
                        r_issued <= r_issued + 4'd1;
                        if (r_issued == LP_NB_M1) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!r_shift_d && w_empty && (r_popped == LP_NB)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE:      r_state <= ST_IDLE;
                ST_ABORT_CLR: r_state <= ST_IDLE;
                default:      r_state <= ST_IDLE;
            endcase
        end
    end

    // FIFO control: byte capture one cycle after each shift, pointer/count bookkeeping, abort flush
    always_ff @(posedge CLKEXT) begin
        if (RST_GLO || w_abort) begin
            r_shift_d <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            r_shift_d <= w_shift;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: data only, no reset needed since reads are gated by BYTE_VALID
    always_ff @(posedge CLKEXT) begin
        if (!RST_GLO && !w_abort && w_push) begin
            r_mem[r_wr_ptr] <= DEB_DIN;
        end
    end

    // The credit rule must make a push into a full FIFO unreachable
    a_no_overflow : assert property (@(posedge CLKEXT) disable iff (RST_GLO)
        !(w_push && (r_count == LP_FULL)));

    assign EN_PISO_DEB  = (r_state == ST_CAPTURE) || (r_state == ST_SHIFT) || (r_state == ST_DRAIN);
    assign CLR_PISO_DEB = (r_state == ST_CLEAR) || (r_state == ST_ABORT_CLR);
    assign SHIFT_DEB    = w_shift;
    assign BYTE_VALID   = !w_empty;
    assign BYTE_OUT     = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign BYTE_IDX     = r_popped;
    assign BYTE_LAST    = !w_empty && (r_popped == LP_NB_M1);
    assign DBG_BUSY     = (r_state != ST_IDLE);
    assign DBG_DONE     = (r_state == ST_DONE);

endmodule
